// File: rtl/tick_updown_cntr.sv
// tick_updown_cntr: a prescaler that divides CLK into a periodic tick. Each
// tick steps a modulo-(CNT_MAX+1) up/down counter.
//
// Ports:
//   CLK            in   system clock (post-BUFG)
//   FPGA_CPU_RESET in   synchronous active-high reset
//   en             in   1 = prescaler runs, 0 = prescaler holds (no ticks)
//   up_dn          in   step direction sampled on tick edges (1 = up)
//   load           in   synchronous load strobe, restarts the tick period
//   load_val       in   value to load; saturated to CNT_MAX
//   tick           out  registered one-cycle pulse per elapsed period
//   count          out  registered counter value, never above CNT_MAX
//   wrap           out  registered one-cycle pulse when count wraps
module tick_updown_cntr #(
  parameter int unsigned CLK_DIV = 200000000,
  parameter int unsigned DIV_W   = 28,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned CNT_MAX = 15
) (
  input  logic             CLK,
  input  logic             FPGA_CPU_RESET,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

  logic [DIV_W-1:0] r_pre;
  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             r_wrap;

  logic             w_tick_edge;
  logic [CNT_W-1:0] w_load_sat;
  logic [CNT_W-1:0] w_count_next;
  logic             w_wrap_next;

  // Tick edge: enabled cycle that closes the current period.
  assign w_tick_edge = en && (r_pre == PRE_LAST);

  // Out-of-range load values saturate to the terminal value.
  assign w_load_sat = (load_val > CNT_TOP) ? CNT_TOP : load_val;

  // Next count and wrap flag for a tick edge in the sampled direction.
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (up_dn) begin
      if (r_count == CNT_TOP) begin
        w_count_next = '0;
        w_wrap_next  = 1'b1;
      end else begin
        w_count_next = r_count + CNT_W'(1);
      end
    end else begin
      if (r_count == '0) begin
        w_count_next = CNT_TOP;
        w_wrap_next  = 1'b1;
      end else begin
        w_count_next = r_count - CNT_W'(1);
      end
    end
  end

  // Prescaler and counter state; reset beats load beats stepping.
  always_ff @(posedge CLK) begin
    if (FPGA_CPU_RESET) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      // A coinciding tick is dropped and the period restarts from zero.
      r_pre   <= '0;
      r_count <= w_load_sat;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= w_tick_edge;
      r_wrap <= w_tick_edge && w_wrap_next;
      if (w_tick_edge) begin
        r_pre   <= '0;
        r_count <= w_count_next;
      end else if (en) begin
        r_pre   <= r_pre + DIV_W'(1);
      end
    end
  end

  assign tick  = r_tick;
  assign count = r_count;
  assign wrap  = r_wrap;

endmodule
